pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Purpose: hazard controller for a 5-stage pipeline: load-use bubbles, redirect flushes, multi-cycle ALU stalls.
// Latency: control outputs are combinational from state and inputs (same cycle); state and counters are registered.
// Backpressure: stalls by dropping PC/IF-ID/ID-EX write enables; holds everything while the multi-cycle unit runs.
//
// Ports:
//   clk, reset_n                     : clock (rising edge) and asynchronous active-low reset
//   id_rs1_address, id_rs2_address   : source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2         : ID instruction actually reads rs1 / rs2
//   ex_rd_address                    : destination register of the EX instruction
//   ex_reg_wren, ex_is_load          : EX writes a register / its result comes from RAM
//   ex_redirect                      : EX resolved a taken branch or jump
//   ex_mc_start, mc_done             : multi-cycle op starting in EX / multi-cycle result valid
//   pc_wren, if_id_wren, id_ex_wren  : pipeline register write enables
//   if_id_flush, id_ex_bubble        : NOP into IF/ID / kill side effects at the ID/EX input
//   busy                             : waiting on the multi-cycle unit
//   stall_count, flush_count         : saturating event counters
module pipeline_hazard_controller (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs1_address,
   input  logic [4:0]  id_rs2_address,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd_address,
   input  logic        ex_reg_wren,
   input  logic        ex_is_load,
   input  logic        ex_redirect,
   input  logic        ex_mc_start,
   input  logic        mc_done,
   output logic        pc_wren,
   output logic        if_id_wren,
   output logic        id_ex_wren,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        busy,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   logic rs1_hit;
   logic rs2_hit;
   logic luh;
   logic stall_evt;
   logic flush_evt;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign rs1_hit = id_uses_rs1 && (id_rs1_address == ex_rd_address);
   assign rs2_hit = id_uses_rs2 && (id_rs2_address == ex_rd_address);
   assign luh     = ex_is_load && ex_reg_wren && (ex_rd_address != 5'd0) && (rs1_hit || rs2_hit);

   assign busy = (state == MC_WAIT);

   always_comb begin
      pc_wren      = 1'b1;
      if_id_wren   = 1'b1;
      id_ex_wren   = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_evt    = 1'b0;
      flush_evt    = 1'b0;
      state_nxt    = state;
      case (state)
         RUN: begin
            if (ex_redirect) begin
               // Wrong-path instructions in IF and ID are discarded; the
               // redirect target is fetched, so all registers still advance.
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               flush_evt    = 1'b1;
            end else if (ex_mc_start) begin
               // A result ready in the start cycle needs no wait at all.
               if (!mc_done) begin
                  pc_wren    = 1'b0;
                  if_id_wren = 1'b0;
                  id_ex_wren = 1'b0;
                  stall_evt  = 1'b1;
                  state_nxt  = MC_WAIT;
               end
            end else if (luh) begin
               // Hold IF and ID; the bubble into EX clears ex_is_load next
               // cycle, so each load-use pair costs exactly one bubble.
               pc_wren      = 1'b0;
               if_id_wren   = 1'b0;
               id_ex_bubble = 1'b1;
               stall_evt    = 1'b1;
            end
         end
         MC_WAIT: begin
            if (mc_done) begin
               state_nxt = RUN;
            end else begin
               pc_wren    = 1'b0;
               if_id_wren = 1'b0;
               id_ex_wren = 1'b0;
               stall_evt  = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RUN;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         state <= state_nxt;
         if (stall_evt && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
         end
         if (flush_evt && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vectors with literal expectations,
// plus a rule-level model compared against every output on every falling edge.
module tb_pipeline_hazard_controller;

   logic        clk;
   logic        reset_n;
   logic [4:0]  id_rs1_address;
   logic [4:0]  id_rs2_address;
   logic        id_uses_rs1;
   logic        id_uses_rs2;
   logic [4:0]  ex_rd_address;
   logic        ex_reg_wren;
   logic        ex_is_load;
   logic        ex_redirect;
   logic        ex_mc_start;
   logic        mc_done;
   logic        pc_wren;
   logic        if_id_wren;
   logic        id_ex_wren;
   logic        if_id_flush;
   logic        id_ex_bubble;
   logic        busy;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   int tests_run = 0;
   int tests_failed = 0;

   pipeline_hazard_controller dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .id_rs1_address (id_rs1_address),
      .id_rs2_address (id_rs2_address),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd_address  (ex_rd_address),
      .ex_reg_wren    (ex_reg_wren),
      .ex_is_load     (ex_is_load),
      .ex_redirect    (ex_redirect),
      .ex_mc_start    (ex_mc_start),
      .mc_done        (mc_done),
      .pc_wren        (pc_wren),
      .if_id_wren     (if_id_wren),
      .id_ex_wren     (id_ex_wren),
      .if_id_flush    (if_id_flush),
      .id_ex_bubble   (id_ex_bubble),
      .busy           (busy),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // Waiting flag plus unbounded integer event tallies; saturation is applied
   // only when the tallies are compared with the 16-bit outputs.
   bit m_wait;
   int m_stalls;
   int m_flushes;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic fl;
      logic bub;
      logic bsy;
      logic stall;
      logic flush;
      logic nwait;
   } exp_t;

   function automatic bit load_dep();
      bit dep;
      dep = 1'b0;
      if (ex_is_load && ex_reg_wren && ex_rd_address != 0) begin
         if (id_uses_rs1 && id_rs1_address == ex_rd_address) dep = 1'b1;
         if (id_uses_rs2 && id_rs2_address == ex_rd_address) dep = 1'b1;
      end
      return dep;
   endfunction

   function automatic exp_t predict(input bit w);
      exp_t e;
      e = '{pc:1, ifid:1, idex:1, fl:0, bub:0, bsy:w, stall:0, flush:0, nwait:0};
      if (w) begin
         if (!mc_done) begin
            e.pc = 0; e.ifid = 0; e.idex = 0; e.stall = 1; e.nwait = 1;
         end
      end else if (ex_redirect) begin
         e.fl = 1; e.bub = 1; e.flush = 1;
      end else if (ex_mc_start && !mc_done) begin
         e.pc = 0; e.ifid = 0; e.idex = 0; e.stall = 1; e.nwait = 1;
      end else if (ex_mc_start && mc_done) begin
         e.nwait = 0;
      end else if (load_dep()) begin
         e.pc = 0; e.ifid = 0; e.bub = 1; e.stall = 1;
      end
      return e;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_wait    <= 1'b0;
         m_stalls  <= 0;
         m_flushes <= 0;
      end else begin
         exp_t e;
         e = predict(m_wait);
         m_wait <= e.nwait;
         if (e.stall) m_stalls <= m_stalls + 1;
         if (e.flush) m_flushes <= m_flushes + 1;
      end
   end

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         exp_t e;
         e = predict(m_wait);
         chk("m_outs", {pc_wren, if_id_wren, id_ex_wren, if_id_flush, id_ex_bubble, busy},
             {e.pc, e.ifid, e.idex, e.fl, e.bub, e.bsy});
         chk("m_stall_count", stall_count, sat16(m_stalls));
         chk("m_flush_count", flush_count, sat16(m_flushes));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      id_rs1_address = 0; id_rs2_address = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rd_address = 0; ex_reg_wren = 0; ex_is_load = 0;
      ex_redirect = 0; ex_mc_start = 0; mc_done = 0;
   endtask

   task automatic set_luh(input logic [4:0] rd);
      idle();
      ex_is_load = 1; ex_reg_wren = 1; ex_rd_address = rd;
      id_uses_rs2 = 1; id_rs2_address = 5;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall_count, 0);
      chk("rst_flush", flush_count, 0);
      chk("rst_outs", {pc_wren, if_id_wren, id_ex_wren, if_id_flush, id_ex_bubble}, 5'b11100);
      #9 reset_n = 1'b1;                       // released between edges (t=12)

      // Load-use on rs2 = x5
      set_luh(5);
      #1;
      chk("luh_outs", {pc_wren, if_id_wren, id_ex_wren, id_ex_bubble}, 4'b0011);
      next_cycle();
      chk("luh_stall", stall_count, 1);
      idle();                                  // bubble removed the load from EX
      #1;
      chk("luh_one_bubble", {pc_wren, if_id_wren, id_ex_bubble}, 3'b110);

      // Same pattern with x0 as destination: no hazard
      next_cycle();
      set_luh(0);
      ex_rd_address = 0; id_rs2_address = 0;
      #1;
      chk("x0_outs", {pc_wren, if_id_wren, id_ex_bubble}, 3'b110);
      next_cycle();
      chk("x0_stall", stall_count, 1);

      // Redirect beats mc_start and luh
      set_luh(5);
      ex_redirect = 1; ex_mc_start = 1;
      #1;
      chk("redir_outs", {pc_wren, if_id_wren, id_ex_wren, if_id_flush, id_ex_bubble}, 5'b11111);
      next_cycle();
      chk("redir_flush", flush_count, 1);
      chk("redir_stall", stall_count, 1);
      chk("redir_busy", busy, 0);

      // Multi-cycle: start, two waiting cycles, done in the third
      idle(); ex_mc_start = 1;
      #1;
      chk("mc_start_wren", {pc_wren, if_id_wren, id_ex_wren}, 3'b000);
      next_cycle();
      idle(); ex_redirect = 1;                 // ignored while waiting
      #1;
      chk("mc_w1", {busy, pc_wren, if_id_wren, id_ex_wren, if_id_flush}, 5'b10000);
      next_cycle();
      idle();
      #1;
      chk("mc_w2", {busy, pc_wren, if_id_wren, id_ex_wren}, 4'b1000);
      next_cycle();
      mc_done = 1;
      #1;
      chk("mc_done_outs", {busy, pc_wren, if_id_wren, id_ex_wren}, 4'b1111);
      next_cycle();
      idle();
      chk("mc_stall", stall_count, 4);         // 1 earlier + 3
      chk("mc_flush_ignored", flush_count, 1);
      chk("mc_back_run", busy, 0);

      // Start and done together: no wait
      ex_mc_start = 1; mc_done = 1;
      #1;
      chk("mc_same_outs", {pc_wren, if_id_wren, id_ex_wren}, 3'b111);
      next_cycle();
      idle();
      chk("mc_same_busy", busy, 0);
      chk("mc_same_stall", stall_count, 4);

      // Reset in the middle of MC_WAIT
      ex_mc_start = 1;
      next_cycle();
      idle();
      chk("pre_rst_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_stall", stall_count, 0);
      chk("arst_flush", flush_count, 0);
      next_cycle();
      #2 reset_n = 1'b1;
      #1;
      chk("post_rst_wren", {busy, pc_wren, if_id_wren, id_ex_wren}, 4'b0111);
      set_luh(5);
      next_cycle();
      chk("post_rst_stall", stall_count, 1);

      // Saturation: 65540 consecutive load-use cycles
      for (int i = 0; i < 65540; i++) next_cycle();
      chk("sat_stall", stall_count, 16'hFFFF);
      next_cycle();
      chk("sat_hold", stall_count, 16'hFFFF);
      idle();
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
